ex_mem_stage: RTL and testbench

//  Execute-to-memory pipeline stage that sits directly downstream of the combinational ALU.
//  It captures the ALU result and zero flag together with the decoded control from the execute stage.
//  It resolves BEQ/BNE branch outcome from the zero flag.
//  It buffers up to two entries (main + skid) so the valid/ready handshake toward the memory stage

---
 rtl/ex_mem_stage.sv | 141 ++++++++++++++
 tb/tb_ex_mem_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// Execute-to-memory pipeline stage: captures ALU result and decoded control, resolves
// BEQ/BNE outcome and flags misaligned accesses, with a two-entry (main + skid) buffer.
module ex_mem_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    alu_result,
  input  logic               alu_zero,
  input  logic               alu_ready,
  input  logic [RADDR_W-1:0] rd_addr,
  input  logic               reg_write,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [XLEN-1:0]    store_data,
  input  logic               branch,
  input  logic               branch_ne,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_result,
  output logic [RADDR_W-1:0] out_rd_addr,
  output logic               out_reg_write,
  output logic               out_mem_read,
  output logic               out_mem_write,
  output logic [XLEN-1:0]    out_store_data,
  output logic               out_br_taken,
  output logic               out_misalign
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0]    result;
    logic [RADDR_W-1:0] rd_addr;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
    logic [XLEN-1:0]    store_data;
    logic               br_taken;
    logic               misalign;
  } entry_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   accept;
  logic   pop;

  // in_ready depends only on registered state, gated low while reset is asserted
  assign in_ready  = rst_n & (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign accept    = in_valid & in_ready & alu_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    in_entry            = '0;
    in_entry.result     = alu_result;
    in_entry.rd_addr    = rd_addr;
    in_entry.reg_write  = reg_write;
    in_entry.mem_read   = mem_read;
    in_entry.mem_write  = mem_write;
    in_entry.store_data = store_data;
    in_entry.br_taken   = branch & (alu_zero ^ branch_ne);
    in_entry.misalign   = (mem_read | mem_write) & (alu_result[1:0] != 2'b00);
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (accept) begin
            state_d = S_ONE;
            main_d  = in_entry;
          end
        end
        S_ONE: begin
          if (accept && pop) begin
            main_d = in_entry;
          end else if (accept) begin
            state_d = S_TWO;
            skid_d  = in_entry;
          end else if (pop) begin
            // popped entry is zeroed so no stale control leaks with out_valid=0
            state_d = S_EMPTY;
            main_d  = '0;
          end
        end
        S_TWO: begin
          if (pop) begin
            state_d = S_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = S_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign out_result     = main_q.result;
  assign out_rd_addr    = main_q.rd_addr;
  assign out_reg_write  = main_q.reg_write;
  assign out_mem_read   = main_q.mem_read;
  assign out_mem_write  = main_q.mem_write;
  assign out_store_data = main_q.store_data;
  assign out_br_taken   = main_q.br_taken;
  assign out_misalign   = main_q.misalign;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: hand-computed expectations checked with immediate assertions.
module tb_ex_mem_stage;

  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;

  logic               clk;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [XLEN-1:0]    alu_result;
  logic               alu_zero;
  logic               alu_ready;
  logic [RADDR_W-1:0] rd_addr;
  logic               reg_write;
  logic               mem_read;
  logic               mem_write;
  logic [XLEN-1:0]    store_data;
  logic               branch;
  logic               branch_ne;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_result;
  logic [RADDR_W-1:0] out_rd_addr;
  logic               out_reg_write;
  logic               out_mem_read;
  logic               out_mem_write;
  logic [XLEN-1:0]    out_store_data;
  logic               out_br_taken;
  logic               out_misalign;

  int n_vec = 0;
  int n_err = 0;

  ex_mem_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_ready(alu_ready),
    .rd_addr(rd_addr), .reg_write(reg_write), .mem_read(mem_read),
    .mem_write(mem_write), .store_data(store_data),
    .branch(branch), .branch_ne(branch_ne),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_store_data(out_store_data),
    .out_br_taken(out_br_taken), .out_misalign(out_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_result = '0; alu_zero = 1'b0;
    alu_ready = 1'b1; rd_addr = '0; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    store_data = '0; branch = 1'b0; branch_ne = 1'b0; out_ready = 1'b0;

    // reset
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_reg_write", out_reg_write, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // single pass
    in_valid = 1'b1; alu_result = 32'h8; rd_addr = 5'd5; reg_write = 1'b1;
    store_data = 32'hCAFE_0001; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("pass_valid", out_valid, 1);
    chk("pass_result", out_result, 32'h8);
    chk("pass_rd", out_rd_addr, 5);
    chk("pass_reg_write", out_reg_write, 1);
    chk("pass_store_data", out_store_data, 32'hCAFE_0001);
    step();
    chk("pass_gone_valid", out_valid, 0);
    chk("pass_gone_reg_write", out_reg_write, 0);

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1; alu_result = 32'h11; rd_addr = 5'd1;
    step();
    chk("bp_ready_after1", in_ready, 1);
    alu_result = 32'h22; rd_addr = 5'd2;
    step();
    in_valid = 1'b0;
    chk("bp_ready_after2", in_ready, 0);
    chk("bp_head", out_result, 32'h11);
    step();
    chk("bp_hold_result", out_result, 32'h11);
    chk("bp_hold_rd", out_rd_addr, 1);
    out_ready = 1'b1;
    step();
    chk("bp_pop2_result", out_result, 32'h22);
    chk("bp_pop2_rd", out_rd_addr, 2);
    chk("bp_pop2_valid", out_valid, 1);
    chk("bp_pop2_in_ready", in_ready, 1);
    step();
    chk("bp_empty", out_valid, 0);

    // branch resolution (second entry accepted while first pops)
    reg_write = 1'b0; in_valid = 1'b1; branch = 1'b1; branch_ne = 1'b0; alu_zero = 1'b1;
    alu_result = 32'h0;
    step();
    branch_ne = 1'b1;
    chk("beq_taken", out_br_taken, 1);
    step();
    in_valid = 1'b0;
    chk("bne_not_taken", out_br_taken, 0);
    chk("bne_valid", out_valid, 1);
    step();
    chk("br_empty", out_valid, 0);
    branch = 1'b0; branch_ne = 1'b0; alu_zero = 1'b0;

    // misalign
    in_valid = 1'b1; mem_write = 1'b1; alu_result = 32'h6; store_data = 32'h1234_5678;
    step();
    chk("mis_flag", out_misalign, 1);
    chk("mis_mem_write", out_mem_write, 1);
    mem_write = 1'b0; mem_read = 1'b1; alu_result = 32'h4;
    step();
    in_valid = 1'b0; mem_read = 1'b0;
    chk("aligned_flag", out_misalign, 0);
    chk("aligned_mem_read", out_mem_read, 1);
    step();
    chk("mis_empty_valid", out_valid, 0);
    chk("mis_empty_mem_read", out_mem_read, 0);

    // alu_ready low blocks accept
    in_valid = 1'b1; alu_ready = 1'b0; alu_result = 32'h77;
    step();
    chk("noalu_valid", out_valid, 0);
    chk("noalu_in_ready", in_ready, 1);
    in_valid = 1'b0; alu_ready = 1'b1;

    // flush from TWO with a pending input
    out_ready = 1'b0; in_valid = 1'b1; reg_write = 1'b1; alu_result = 32'h33;
    step();
    alu_result = 32'h44;
    step();
    chk("fl_two_in_ready", in_ready, 0);
    flush = 1'b1; alu_result = 32'h55;
    step();
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_reg_write", out_reg_write, 0);
    chk("fl_result", out_result, 0);
    in_valid = 1'b0;
    step();
    chk("fl_dropped", out_valid, 0);

    // reset mid-transfer
    in_valid = 1'b1; alu_result = 32'h99;
    step();
    in_valid = 1'b0;
    chk("mid_valid", out_valid, 1);
    rst_n = 1'b0;
    step();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_result", out_result, 0);
    rst_n = 1'b1;
    step();
    chk("mid_rel_valid", out_valid, 0);
    chk("mid_rel_in_ready", in_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
